// File: rtl/vga_sprite_engine_if.sv
// Register write bus of the VGA sprite engine.
// One write per cycle in which wren is high.
interface vga_sprite_engine_if #(
  parameter int ADDR_W = 9
);
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       ldr;

  modport master (output wren, addr, ldr);
  modport slave  (input  wren, addr, ldr);
endinterface

// File: rtl/vga_sprite_engine.sv
// VGA timing plus N-sprite compositor.
// Sprite geometry is double-buffered and latched at vblank entry.
module vga_sprite_engine #(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPRITE_SIZE = 16,
  parameter int         H_DISPLAY   = 640,
  parameter int         H_FRONT     = 16,
  parameter int         H_SYNC      = 96,
  parameter int         H_BACK      = 48,
  parameter int         V_DISPLAY   = 480,
  parameter int         V_FRONT     = 10,
  parameter int         V_SYNC      = 2,
  parameter int         V_BACK      = 33,
  parameter logic [2:0] BG_RESET    = 3'b010,
  parameter int         ADDR_W      = 9
) (
  input  logic               clk_50_mhz,
  input  logic               rst_n,
  vga_sprite_engine_if.slave bus,
  output logic [2:0]         rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               irq_vsync,
  output logic [15:0]        frame_count
);
  localparam int NS = NUM_SPRITES;
  localparam int SS = SPRITE_SIZE;
  localparam int RW = (SS > 1) ? $clog2(SS) : 1;
  localparam int IW = ADDR_W - 5;

  localparam logic [10:0] LINE_END =
    11'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] PAGE_END =
    11'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] HS_LO = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_HI = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_LO = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_HI = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [10:0] H_DISP = 11'(H_DISPLAY);
  localparam logic [10:0] V_DISP = 11'(V_DISPLAY);
  localparam logic [10:0] V_LAST = 11'(V_DISPLAY - 1);

  localparam logic [ADDR_W-1:0] A_BG  = ADDR_W'(NS * 32);
  localparam logic [ADDR_W-1:0] A_ACK = ADDR_W'(NS * 32 + 1);

  logic          r_tick;
  logic [10:0]   r_h;
  logic [10:0]   r_v;
  logic [2:0]    r_bg;
  logic [SS-1:0] r_bmp [NS][SS];
  logic [9:0]    r_xp  [NS];
  logic [9:0]    r_yp  [NS];
  logic [9:0]    r_xa  [NS];
  logic [9:0]    r_ya  [NS];
  logic [2:0]    r_cp  [NS];
  logic [2:0]    r_ca  [NS];
  logic [NS-1:0] r_ep;
  logic [NS-1:0] r_ea;

  logic [IW-1:0] w_idx;
  logic [4:0]    w_off;
  logic          w_spr_wr;
  logic          w_bg_wr;
  logic          w_ack;
  logic          w_latch;
  logic [2:0]    w_pix;
  logic [NS-1:0] w_hit;
  logic [10:0]   w_dx [NS];
  logic [10:0]   w_dy [NS];

  assign w_idx    = bus.addr[ADDR_W-1:5];
  assign w_off    = bus.addr[4:0];
  assign w_spr_wr = bus.wren && ({1'b0, w_idx} < (IW+1)'(NS));
  assign w_bg_wr  = bus.wren && (bus.addr == A_BG);
  assign w_ack    = bus.wren && (bus.addr == A_ACK);
  assign w_latch  = r_tick && (r_h == LINE_END) && (r_v == V_LAST);

  // Walk from the highest index down so the lowest hit wins.
  always_comb begin
    w_pix = r_bg;
    w_hit = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      w_dx[s]  = r_h - {1'b0, r_xa[s]};
      w_dy[s]  = r_v - {1'b0, r_ya[s]};
      w_hit[s] = r_ea[s]
        && (r_h >= {1'b0, r_xa[s]}) && (w_dx[s] < 11'(SS))
        && (r_v >= {1'b0, r_ya[s]}) && (w_dy[s] < 11'(SS))
        && r_bmp[s][w_dy[s][RW-1:0]][RW'(SS - 1) - w_dx[s][RW-1:0]];
      if (w_hit[s]) w_pix = r_ca[s];
    end
    if (r_h >= H_DISP || r_v >= V_DISP) w_pix = '0;
  end

  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tick      <= 1'b0;
      r_h         <= '0;
      r_v         <= '0;
      rgb         <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      irq_vsync   <= 1'b0;
      frame_count <= '0;
      r_bg        <= BG_RESET;
    end else begin
      r_tick <= ~r_tick;
      if (r_tick) begin
        rgb   <= w_pix;
        hsync <= (r_h >= HS_LO) && (r_h < HS_HI);
        vsync <= (r_v >= VS_LO) && (r_v < VS_HI);
        if (r_h == LINE_END) begin
          r_h <= '0;
          r_v <= (r_v == PAGE_END) ? '0 : r_v + 11'd1;
        end else begin
          r_h <= r_h + 11'd1;
        end
      end
      if (w_latch) begin
        irq_vsync   <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else if (w_ack) begin
        irq_vsync <= 1'b0;
      end
      if (w_bg_wr) r_bg <= bus.ldr[2:0];
    end
  end

  // Active copies take the pre-edge pending values.
  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_ep <= '0;
      r_ea <= '0;
      for (int s = 0; s < NS; s++) begin
        r_xp[s] <= '0;
        r_yp[s] <= '0;
        r_xa[s] <= '0;
        r_ya[s] <= '0;
        r_cp[s] <= '0;
        r_ca[s] <= '0;
        for (int r = 0; r < SS; r++) r_bmp[s][r] <= '0;
      end
    end else begin
      if (w_latch) begin
        r_ea <= r_ep;
        for (int s = 0; s < NS; s++) begin
          r_xa[s] <= r_xp[s];
          r_ya[s] <= r_yp[s];
          r_ca[s] <= r_cp[s];
        end
      end
      if (w_spr_wr) begin
        for (int s = 0; s < NS; s++) begin
          if (w_idx == IW'(s)) begin
            unique case (1'b1)
              (w_off < 5'(SS)):
                r_bmp[s][w_off[RW-1:0]] <= bus.ldr[SS-1:0];
              (w_off == 5'd16): r_xp[s] <= bus.ldr[9:0];
              (w_off == 5'd17): r_yp[s] <= bus.ldr[9:0];
              (w_off == 5'd18): r_cp[s] <= bus.ldr[2:0];
              (w_off == 5'd19): r_ep[s] <= bus.ldr[0];
              default: ;
            endcase
          end
        end
      end
    end
  end
endmodule
